// File: rtl/cmplx_stream_pkg.sv
// rtl/cmplx_stream_pkg.sv - shared types and helpers for the complex result stream
package cmplx_stream_pkg;

  localparam int DEF_SIZE   = 16;
  localparam int DEF_WIDTH  = 64;
  localparam int DEF_NWORDS = 2 * DEF_SIZE;

  // Number of bus words for a result of 'size' complex elements
  function automatic int nwords(input int size);
    return 2 * size;
  endfunction

  // Index width for n words, never narrower than one bit
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0]         data;
    logic [idx_w(DEF_NWORDS)-1:0] idx;
    logic                         imag;
    logic                         last;
  } beat_t;

endpackage

// File: rtl/complex_result_serializer.sv
// rtl/complex_result_serializer.sv - captures a complex result bus and streams it word by word
module complex_result_serializer
  import cmplx_stream_pkg::*;
#(
  parameter int SIZE  = 16,
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic                           res_valid_i,
  output logic                           res_ready_o,
  input  logic [2*SIZE-1:0][WIDTH-1:0]   result_i,
  output logic                           m_valid_o,
  input  logic                           m_ready_i,
  output logic [WIDTH-1:0]               m_data_o,
  output logic [$clog2(2*SIZE)-1:0]      m_idx_o,
  output logic                           m_imag_o,
  output logic                           m_last_o,
  output logic                           busy_o,
  output logic [CNT_W-1:0]               done_cnt_o
);

  localparam int NW = nwords(SIZE);
  localparam int IW = $clog2(2*SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

  state_t           state, state_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_inc;
  logic             capture;
  logic             fire;
  logic [WIDTH-1:0] words_q [NW];

  // State, index and completed-matrix counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (cnt_inc) cnt <= cnt + 1'b1;
    end
  end

  // Result buffer is data-only storage, loaded once per accepted matrix
  always_ff @(posedge clk_i) begin
    if (capture) begin
      for (int k = 0; k < NW; k++) words_q[k] <= result_i[k];
    end
  end

  // Handshakes, next state and stream outputs; flush overrides normal progress
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    cnt_inc     = 1'b0;
    res_ready_o = (state == IDLE) && !rst_i && !flush_i;
    m_valid_o   = (state == STREAM) && !rst_i;
    busy_o      = (state == STREAM) && !rst_i;
    capture     = res_valid_i && res_ready_o;
    fire        = m_valid_o && m_ready_i;
    m_data_o    = words_q[idx];
    m_idx_o     = idx;
    m_imag_o    = idx[0];
    m_last_o    = (idx == LAST_IDX);
    if (flush_i) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            state_nxt = STREAM;
            idx_nxt   = '0;
          end
        end
        STREAM: begin
          if (fire) begin
            if (m_last_o) begin
              state_nxt = IDLE;
              idx_nxt   = '0;
              cnt_inc   = 1'b1;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign done_cnt_o = cnt;

endmodule

// File: tb/tb_complex_result_serializer.sv
// tb/tb_complex_result_serializer.sv - randomized self-checking bench with queue reference model
module tb_complex_result_serializer;

  localparam int SIZE  = 16;
  localparam int WIDTH = 64;
  localparam int CNT_W = 2;
  localparam int NW    = 2 * SIZE;
  localparam int IW    = $clog2(NW);

  logic                         clk_i = 1'b0;
  logic                         rst_i = 1'b1;
  logic                         flush_i = 1'b0;
  logic                         res_valid_i = 1'b0;
  logic                         res_ready_o;
  logic [NW-1:0][WIDTH-1:0]     result_i = '0;
  logic                         m_valid_o;
  logic                         m_ready_i = 1'b0;
  logic [WIDTH-1:0]             m_data_o;
  logic [IW-1:0]                m_idx_o;
  logic                         m_imag_o;
  logic                         m_last_o;
  logic                         busy_o;
  logic [CNT_W-1:0]             done_cnt_o;

  complex_result_serializer #(.SIZE(SIZE), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .result_i(result_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .m_idx_o(m_idx_o), .m_imag_o(m_imag_o), .m_last_o(m_last_o),
    .busy_o(busy_o), .done_cnt_o(done_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: a matrix is a queue of words still owed downstream
  bit          held = 0;
  logic [63:0] q[$];
  int          done_ref = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    bit exp_valid, exp_ready;
    int pos;
    exp_valid = held && !rst_i;
    exp_ready = !held && !rst_i && !flush_i;
    chk("res_ready", 64'(res_ready_o), 64'(exp_ready));
    chk("m_valid", 64'(m_valid_o), 64'(exp_valid));
    chk("busy", 64'(busy_o), 64'(exp_valid));
    chk("done_cnt", 64'(done_cnt_o), 64'(done_ref));
    if (exp_valid) begin
      pos = NW - q.size();
      chk("m_data", m_data_o, q[0]);
      chk("m_idx", 64'(m_idx_o), 64'(pos));
      chk("m_imag", 64'(m_imag_o), 64'(pos % 2));
      chk("m_last", 64'(m_last_o), 64'(pos == NW - 1));
    end
  endtask

  // one clock: check settled outputs, advance model at the edge, return at negedge
  task automatic tick();
    #1 compare_outputs();
    @(posedge clk_i);
    if (rst_i) begin
      held = 0; q = {}; done_ref = 0;
    end else if (flush_i) begin
      held = 0; q = {};
    end else if (!held) begin
      if (res_valid_i) begin
        held = 1; q = {};
        for (int k = 0; k < NW; k++) q.push_back(result_i[k]);
      end
    end else if (m_ready_i) begin
      void'(q.pop_front());
      if (q.size() == 0) begin
        held = 0;
        done_ref = (done_ref + 1) % (1 << CNT_W);
      end
    end
    @(negedge clk_i);
  endtask

  task automatic rand_payload();
    for (int k = 0; k < NW; k++) result_i[k] = {$urandom, $urandom};
  endtask

  initial begin
    int guard;
    @(negedge clk_i);
    // reset held with upstream valid asserted
    rst_i = 1; res_valid_i = 1; rand_payload();
    repeat (3) tick();
    rst_i = 0;

    // basic drain of 9.0 + 2.0i in every element
    for (int k = 0; k < SIZE; k++) begin
      result_i[2*k]   = 64'h4022000000000000;
      result_i[2*k+1] = 64'h4000000000000000;
    end
    res_valid_i = 1; m_ready_i = 1;
    tick();
    res_valid_i = 0;
    repeat (40) tick();

    // random backpressure and random upstream activity
    for (int c = 0; c < 400; c++) begin
      m_ready_i = $urandom_range(0, 1);
      if (!held) begin
        res_valid_i = $urandom_range(0, 1);
        rand_payload();
      end else res_valid_i = $urandom_range(0, 1);
      tick();
    end
    guard = 0;
    m_ready_i = 1; res_valid_i = 0;
    while (held && guard < 100) begin tick(); guard++; end
    chk("drain_bound", 64'(held), 64'(0));

    // back-to-back: valid held high across two distinct payloads
    for (int k = 0; k < NW; k++) result_i[k] = 64'h1 | (64'(k) << 8);
    res_valid_i = 1;
    tick();
    for (int k = 0; k < NW; k++) result_i[k] = 64'h2 | (64'(k) << 8);
    repeat (NW + 1) tick();
    res_valid_i = 0;
    repeat (NW + 2) tick();

    // flush while the word at index 10 is presented
    rand_payload(); res_valid_i = 1;
    tick();
    res_valid_i = 0;
    guard = 0;
    while (!(held && q.size() == NW - 10) && guard < 100) begin tick(); guard++; end
    chk("flush_reach", 64'(q.size()), 64'(NW - 10));
    flush_i = 1; res_valid_i = 1;
    tick();
    flush_i = 0; res_valid_i = 0;
    tick();
    rand_payload(); res_valid_i = 1;
    tick();
    res_valid_i = 0;
    repeat (NW + 2) tick();

    // five full matrices to exercise counter wrap
    for (int m = 0; m < 5; m++) begin
      rand_payload(); res_valid_i = 1;
      tick();
      res_valid_i = 0;
      repeat (NW) tick();
    end

    // random flushes and resets mixed with traffic
    for (int c = 0; c < 500; c++) begin
      m_ready_i = $urandom_range(0, 3) != 0;
      res_valid_i = $urandom_range(0, 1);
      flush_i = ($urandom_range(0, 40) == 0);
      rst_i = ($urandom_range(0, 150) == 0);
      if (!held) rand_payload();
      tick();
    end
    rst_i = 0; flush_i = 0; res_valid_i = 0;
    repeat (NW + 2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
